// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ARB_PORTS  = 2;
  // Widths of the latched command fields; the arbiter's ADDR_WIDTH/DATA_WIDTH must not exceed these.
  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } arb_state_e;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic                  we;
    logic [3:0]            be;
  } arb_cmd_t;

  function automatic logic onehot_to_idx(input logic [ARB_PORTS-1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker_2.sv
// Combinational two-way round-robin selector: on contention the port that did not win last goes.
module rr_picker_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for memory_system's single data port (CPU LSU = port 0).
// Optional DMEM_ARB_STATS_EN adds per-port grant and timeout counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]              req_we,
  input  logic [7:0]              req_be,
  output logic [1:0]              gnt,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [3:0]              mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [63:0]             stat_grants,
  output logic [31:0]             stat_timeouts
`endif
);

  arb_state_e state_q;
  arb_cmd_t   cmd_q;
  arb_cmd_t   cmd_sel;
  logic       last_q;
  logic       owner_q;
  logic [7:0] cnt_q;
  logic [1:0] win;
  logic       win_idx;
  logic       grant_ok;
  logic       timeout_hit;

  rr_picker_2 u_picker (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  assign win_idx     = onehot_to_idx(win);
  // Stale mem_ready from the previous access must clear before a new command can start.
  assign grant_ok    = (state_q == IDLE) && (|req) && !mem_ready;
  assign gnt         = grant_ok ? win : 2'b00;
  assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cmd_sel       = '0;
    cmd_sel.addr  = win_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    cmd_sel.wdata = win_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    cmd_sel.we    = win_idx ? req_we[1] : req_we[0];
    cmd_sel.be    = win_idx ? req_be[7:4] : req_be[3:0];
  end

  assign mem_addr  = cmd_q.addr[ADDR_WIDTH-1:0];
  assign mem_wdata = cmd_q.wdata[DATA_WIDTH-1:0];
  assign mem_be    = cmd_q.be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= 8'd0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (grant_ok) begin
            cmd_q     <= cmd_sel;
            owner_q   <= win_idx;
            last_q    <= win_idx;
            cnt_q     <= 8'd0;
            mem_read  <= !cmd_sel.we;
            mem_write <= cmd_sel.we;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready || timeout_hit) begin
            rsp_rdata <= (mem_ready && !cmd_q.we) ? mem_rdata : '0;
            rsp_err   <= !mem_ready;
            rsp_valid <= owner_q ? 2'b10 : 2'b01;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state_q   <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DRAIN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] grants0_q, grants1_q, timeouts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grants0_q  <= 32'd0;
      grants1_q  <= 32'd0;
      timeouts_q <= 32'd0;
    end else begin
      if (gnt[0]) grants0_q <= grants0_q + 32'd1;
      if (gnt[1]) grants1_q <= grants1_q + 32'd1;
      if (state_q == ISSUE && !mem_ready && timeout_hit) timeouts_q <= timeouts_q + 32'd1;
    end
  end

  assign stat_grants   = {grants1_q, grants0_q};
  assign stat_timeouts = timeouts_q;
`endif

endmodule
